// File: rtl/axis_spi_reg_bridge_if.sv
// Byte-wide AXI-Stream link between the register bridge and the SPI master.
interface axis_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/axis_spi_reg_bridge.sv
// Register-access bridge: turns a read/write command into a lockstep SPI byte
// frame over AXI-Stream and assembles the returned bytes into a response.
module axis_spi_reg_bridge #(
  parameter int unsigned DATA_BYTES = 2,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_rw_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [8*DATA_BYTES-1:0] cmd_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [8*DATA_BYTES-1:0] rsp_rdata_o,
  output logic                    rsp_err_o,
  axis_if.master                  m_axis,
  axis_if.slave                   s_axis
);

  localparam int unsigned DW    = 8 * DATA_BYTES;
  localparam int unsigned IDX_W = $clog2(DATA_BYTES + 1);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, RECV, RESP} state_t;

  state_t            state_q, state_d;
  logic              rw_q;
  logic [6:0]        addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW-1:0]     rdata_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  tmo_q;
  logic              last_byte;
  logic              tmo_hit;
  logic [7:0]        wdata_byte;
  logic [7:0]        tx_byte;

  // idx_q is the frame position of the byte in flight: 0 = header, 1 = MS data byte
  assign last_byte = (idx_q == IDX_W'(DATA_BYTES));
  assign tmo_hit   = (tmo_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    wdata_byte = '0;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (idx_q == IDX_W'(DATA_BYTES - i)) wdata_byte = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    tx_byte = {rw_q, addr_q};
    if (idx_q != '0) tx_byte = rw_q ? 8'h00 : wdata_byte;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Outputs are gated by rst_i so the bus is quiet for the whole reset pulse
  always_comb begin
    state_d       = state_q;
    cmd_ready_o   = 1'b0;
    rsp_valid_o   = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = 8'h00;
    m_axis.tlast  = 1'b0;
    s_axis.tready = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          cmd_ready_o   = 1'b1;
          s_axis.tready = 1'b1;
          if (cmd_valid_i) state_d = SEND;
        end
        SEND: begin
          m_axis.tvalid = 1'b1;
          m_axis.tdata  = tx_byte;
          m_axis.tlast  = last_byte;
          if (m_axis.tready) state_d = RECV;
        end
        RECV: begin
          s_axis.tready = 1'b1;
          if (s_axis.tvalid)  state_d = last_byte ? RESP : SEND;
          else if (tmo_hit)   state_d = RESP;
        end
        RESP: begin
          rsp_valid_o = 1'b1;
          if (rsp_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      tmo_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            rw_q    <= cmd_rw_i;
            addr_q  <= 7'(cmd_addr_i);
            wdata_q <= cmd_wdata_i;
            rdata_q <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            tmo_q   <= '0;
          end
        end
        SEND: begin
          if (m_axis.tready) tmo_q <= '0;
        end
        RECV: begin
          if (s_axis.tvalid) begin
            if (s_axis.tlast != last_byte) err_q <= 1'b1;
            // Bytes land at their final position so a timeout leaves the rest zero
            for (int unsigned i = 0; i < DATA_BYTES; i++) begin
              if (idx_q == IDX_W'(DATA_BYTES - i)) rdata_q[8*i +: 8] <= s_axis.tdata;
            end
            if (!last_byte) idx_q <= idx_q + 1'b1;
            tmo_q <= '0;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_axis_spi_reg_bridge.sv
// Directed bench for axis_spi_reg_bridge (DATA_BYTES=2, ADDR_WIDTH=7, TIMEOUT=16).
module tb_axis_spi_reg_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  axis_if m_if ();
  axis_if s_if ();

  axis_spi_reg_bridge #(
    .DATA_BYTES (2),
    .ADDR_WIDTH (7),
    .TIMEOUT    (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_rw_i    (cmd_rw),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .m_axis      (m_if),
    .s_axis      (s_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_cmd(input logic rw, input logic [6:0] addr, input logic [15:0] wd);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wd;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] data, input logic last);
    int n = 0;
    while (!m_if.tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_tvalid"}, 32'(m_if.tvalid), 32'd1);
    check({tag, "_tdata"},  32'(m_if.tdata),  32'(data));
    check({tag, "_tlast"},  32'(m_if.tlast),  32'(last));
    m_if.tready = 1'b1;
    @(negedge clk);
    m_if.tready = 1'b0;
  endtask

  task automatic return_byte(input logic [7:0] data, input logic last);
    check("s_tready_recv", 32'(s_if.tready), 32'd1);
    s_if.tvalid = 1'b1;
    s_if.tdata  = data;
    s_if.tlast  = last;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = 8'h00;
  endtask

  task automatic get_rsp(input string tag, input logic [15:0] rdata, input logic err,
                         input int unsigned hold);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rdata"}, 32'(rsp_rdata), 32'(rdata));
    check({tag, "_err"},   32'(rsp_err),   32'(err));
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_rdata"}, 32'(rsp_rdata), 32'(rdata));
      check({tag, "_hold_cmdrdy"}, 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_single"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_rw      = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    rsp_ready   = 1'b0;
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = 8'h00;
    s_if.tlast  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready),   32'd0);
    check("rst_rsp_valid", 32'(rsp_valid),   32'd0);
    check("rst_m_tvalid",  32'(m_if.tvalid), 32'd0);
    check("rst_m_tdata",   32'(m_if.tdata),  32'd0);
    check("rst_m_tlast",   32'(m_if.tlast),  32'd0);
    check("rst_s_tready",  32'(s_if.tready), 32'd0);
    check("rst_rdata",     32'(rsp_rdata),   32'd0);
    check("rst_err",       32'(rsp_err),     32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // write 0x15 <- 0xBEEF with loopback slave
    send_cmd(1'b0, 7'h15, 16'hBEEF);
    expect_byte("wr_b0", 8'h15, 1'b0);
    return_byte(8'h15, 1'b0);
    expect_byte("wr_b1", 8'hBE, 1'b0);
    return_byte(8'hBE, 1'b0);
    expect_byte("wr_b2", 8'hEF, 1'b1);
    return_byte(8'hEF, 1'b1);
    get_rsp("wr_rsp", 16'hBEEF, 1'b0, 0);

    // read 0x2A, slave returns FF 12 34
    send_cmd(1'b1, 7'h2A, 16'h0000);
    expect_byte("rd_b0", 8'hAA, 1'b0);
    return_byte(8'hFF, 1'b0);
    expect_byte("rd_b1", 8'h00, 1'b0);
    return_byte(8'h12, 1'b0);
    expect_byte("rd_b2", 8'h00, 1'b1);
    return_byte(8'h34, 1'b1);
    get_rsp("rd_rsp", 16'h1234, 1'b0, 0);

    // read with early tlast on second returned byte
    send_cmd(1'b1, 7'h01, 16'h0000);
    expect_byte("tl_b0", 8'h81, 1'b0);
    return_byte(8'h00, 1'b0);
    expect_byte("tl_b1", 8'h00, 1'b0);
    return_byte(8'h56, 1'b1);
    expect_byte("tl_b2", 8'h00, 1'b1);
    return_byte(8'h78, 1'b1);
    get_rsp("tl_rsp", 16'h5678, 1'b1, 0);

    // timeout after byte0
    send_cmd(1'b1, 7'h2A, 16'h0000);
    expect_byte("to_b0", 8'hAA, 1'b0);
    return_byte(8'hFF, 1'b0);
    expect_byte("to_b1", 8'h00, 1'b0);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("to_latency_ok", 32'(n >= 1 && n <= 17), 32'd1);
    check("to_no_more_tx", 32'(m_if.tvalid), 32'd0);
    get_rsp("to_rsp", 16'h0000, 1'b1, 0);
    check("late_s_tready", 32'(s_if.tready), 32'd1);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'h99;
    s_if.tlast  = 1'b1;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    check("late_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check("late_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("late_idle_m_tvalid",  32'(m_if.tvalid), 32'd0);

    // response backpressure for 10 cycles
    send_cmd(1'b0, 7'h7F, 16'h0102);
    expect_byte("bp_b0", 8'h7F, 1'b0);
    return_byte(8'h7F, 1'b0);
    expect_byte("bp_b1", 8'h01, 1'b0);
    return_byte(8'h01, 1'b0);
    expect_byte("bp_b2", 8'h02, 1'b1);
    return_byte(8'h02, 1'b1);
    get_rsp("bp_rsp", 16'h0102, 1'b0, 10);
    check("bp_next_ready", 32'(cmd_ready), 32'd1);
    send_cmd(1'b1, 7'h10, 16'hFFFF);
    check("bp_next_accepted_tvalid", 32'(m_if.tvalid), 32'd1);
    expect_byte("bp2_b0", 8'h90, 1'b0);
    return_byte(8'h00, 1'b0);
    expect_byte("bp2_b1", 8'h00, 1'b0);
    return_byte(8'hAB, 1'b0);
    expect_byte("bp2_b2", 8'h00, 1'b1);
    return_byte(8'hCD, 1'b1);
    get_rsp("bp2_rsp", 16'hABCD, 1'b0, 0);

    // reset pulse during SEND of byte 1
    send_cmd(1'b0, 7'h33, 16'h1122);
    expect_byte("rs_b0", 8'h33, 1'b0);
    return_byte(8'h33, 1'b0);
    check("rs_pre_tvalid", 32'(m_if.tvalid), 32'd1);
    check("rs_pre_tdata",  32'(m_if.tdata),  32'h11);
    rst = 1'b1;
    #1;
    check("rs_in_tvalid",  32'(m_if.tvalid), 32'd0);
    @(negedge clk);
    check("rs_in2_tvalid",  32'(m_if.tvalid), 32'd0);
    check("rs_in2_cmd_rdy", 32'(cmd_ready),   32'd0);
    check("rs_in2_s_tready", 32'(s_if.tready), 32'd0);
    rst = 1'b0;
    #1;
    check("rs_post_cmd_rdy", 32'(cmd_ready), 32'd1);
    check("rs_post_rdata",   32'(rsp_rdata), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rs_no_rsp",    32'(rsp_valid),   32'd0);
      check("rs_no_tvalid", 32'(m_if.tvalid), 32'd0);
    end
    send_cmd(1'b1, 7'h05, 16'h0000);
    expect_byte("rs2_b0", 8'h85, 1'b0);
    return_byte(8'hFF, 1'b0);
    expect_byte("rs2_b1", 8'h00, 1'b0);
    return_byte(8'hCA, 1'b0);
    expect_byte("rs2_b2", 8'h00, 1'b1);
    return_byte(8'hFE, 1'b1);
    get_rsp("rs2_rsp", 16'hCAFE, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_spi_reg_bridge.md
AXIS_SPI_REG_BRIDGE -- requirements
Module: axis_spi_reg_bridge

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 2: data bytes per register access, range 1..4.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7: register address width, range 1..7.
REQ-003 SHALL have parameter TIMEOUT, default 1024: maximum clk_i cycles to wait for each returned byte, minimum 2.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_i, input, 1 bit: synchronous reset, active-high.
REQ-007 SHALL have ports cmd_valid_i (input, 1) and cmd_ready_o (output, 1): command handshake.
REQ-008 SHALL have port cmd_rw_i, input, 1 bit: 1 = read, 0 = write.
REQ-009 SHALL have ports cmd_addr_i (input, ADDR_WIDTH) and cmd_wdata_i (input, 8*DATA_BYTES): register address and write data.
REQ-010 SHALL have ports rsp_valid_o (output, 1) and rsp_ready_i (input, 1): response handshake.
REQ-011 SHALL have ports rsp_rdata_o (output, 8*DATA_BYTES) and rsp_err_o (output, 1): assembled read data and error flag.
REQ-012 SHALL have m_axis, an axis_if.master with 8-bit tdata and tlast: byte frames sent to the SPI master.
REQ-013 SHALL have s_axis, an axis_if.slave with 8-bit tdata and tlast: bytes returned by the SPI master.

Function
REQ-014 SHALL implement the states IDLE, SEND, RECV and RESP.
REQ-015 SHALL drive cmd_ready_o high only in IDLE; a command is accepted on cmd_valid_i & cmd_ready_o.
REQ-016 SHALL register rw, addr and wdata on accept and enter SEND on the next cycle.
REQ-017 SHALL send a frame of 1+DATA_BYTES bytes: byte0 = {rw, addr zero-extended to 7 bits}; then data bytes, most significant first.
REQ-018 SHALL send wdata as the data bytes for a write and 0x00 for a read.
REQ-019 SHALL, in SEND, hold m_axis.tvalid high with stable tdata and tlast until the m_axis handshake, then enter RECV.
REQ-020 SHALL assert m_axis.tlast only on the final byte of the frame.
REQ-021 SHALL, in RECV, drive s_axis.tready high and on the s_axis handshake capture the byte.
REQ-022 SHALL, after the RECV capture, return to SEND if bytes remain, else enter RESP (strict lockstep: one byte sent, one received).
REQ-023 SHALL discard the returned byte paired with byte0; returned data bytes shift into rsp_rdata_o, most significant first.
REQ-024 SHALL set the sticky rsp_err_o if a received tlast differs from the tlast of the byte just sent.
REQ-025 SHALL count cycles in RECV and reset the count on each handshake; reaching TIMEOUT SHALL set rsp_err_o, enter RESP, and leave unreceived rdata bytes at 0.
REQ-026 SHALL assert rsp_valid_o in RESP, the cycle after the final capture or the timeout, for reads and writes alike.
REQ-027 SHALL hold rsp_rdata_o and rsp_err_o stable until rsp_valid_o & rsp_ready_i, then return to IDLE.
REQ-028 SHALL clear rdata and err at the next command accept.
REQ-029 SHALL drive s_axis.tready high in IDLE and silently drop any byte arriving there (flushes late bytes after a timeout).
REQ-030 SHALL keep s_axis.tready low in SEND and RESP.
REQ-031 SHALL hold m_axis.tvalid low outside SEND.
REQ-032 SHALL take exactly 1+DATA_BYTES m_axis handshakes per command, never more.

Reset
REQ-033 SHALL, while rst_i is high at a clk_i edge, force IDLE and clear all counters, rdata and err.
REQ-034 SHALL hold these output values during reset: cmd_ready_o=0, rsp_valid_o=0, m_axis.tvalid=0, m_axis.tlast=0, m_axis.tdata=0x00, s_axis.tready=0.
REQ-035 SHALL, on reset mid-frame, abandon the frame with no response; the first cycle after reset is IDLE with cmd_ready_o=1.

Verification
REQ-036 SHALL pass: write addr=0x15, wdata=0xBEEF, DATA_BYTES=2, loopback model -> m_axis bytes 0x15, 0xBE, 0xEF, tlast on 0xEF only; one response, err=0.
REQ-037 SHALL pass: read addr=0x2A, slave returns 0xFF, 0x12, 0x34 with tlast on the third -> bytes sent 0xAA, 0x00, 0x00; rsp_rdata_o=0x1234, err=0.
REQ-038 SHALL pass: read where the slave returns the second byte with tlast=1 -> rsp_err_o=1; frame still completes 3 bytes.
REQ-039 SHALL pass: read where the slave stops after byte0, TIMEOUT=16 -> rsp_valid_o within 17 cycles of the last handshake, err=1, rdata=0x0000; a late byte in IDLE is dropped.
REQ-040 SHALL pass: rsp_ready_i held low 10 cycles -> response stable, cmd_ready_o=0 throughout; next command is accepted the cycle after the handshake.
REQ-041 SHALL pass: rst_i pulsed during SEND of byte 1 -> m_axis.tvalid=0 during reset, no response, and a new command completes normally.
